// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
//   Two-way intersection phase sequencer with pedestrian service.
//   Sequence NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G. Each phase
//   lasts a whole number of ticks; a tick is one CLK cycle in TICK_DIV.
//   A latched pedestrian request is served by the next all-red phase, which
//   then runs for PED_TIME ticks with the walk lamp on.
//
// Ports
//   CLK            clock, all state on posedge
//   CLR            synchronous active-high reset, highest priority
//   en             run enable; 0 freezes prescaler, countdown, phase and walk
//   ped_req        pedestrian request, level-sampled every cycle
//   ped_ack        high in the cycle a request is latched or served directly
//   walk           pedestrian walk lamp (only in a served all-red phase)
//   ns_g/ns_y/ns_r north-south lamps, exactly one high
//   ew_g/ew_y/ew_r east-west lamps, exactly one high
//   giay1/giay0    BCD tens/ones of ticks remaining in the phase (never 00)
//   phase          current state code
module traffic_phase_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int G_TIME   = 25,
  parameter int Y_TIME   = 3,
  parameter int AR_TIME  = 1,
  parameter int PED_TIME = 8
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       en,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic       walk,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic [3:0] giay1,
  output logic [3:0] giay0,
  output logic [2:0] phase
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [2:0] ST_NS_G = 3'd0;
  localparam logic [2:0] ST_NS_Y = 3'd1;
  localparam logic [2:0] ST_AR1  = 3'd2;
  localparam logic [2:0] ST_EW_G = 3'd3;
  localparam logic [2:0] ST_EW_Y = 3'd4;
  localparam logic [2:0] ST_AR2  = 3'd5;

  // Durations as two BCD digits {tens, ones}; legal range is 1..99.
  function automatic logic [7:0] to_bcd(input int t);
    return {4'(t / 10), 4'(t % 10)};
  endfunction

  localparam logic [7:0] G_BCD   = to_bcd(G_TIME);
  localparam logic [7:0] Y_BCD   = to_bcd(Y_TIME);
  localparam logic [7:0] AR_BCD  = to_bcd(AR_TIME);
  localparam logic [7:0] PED_BCD = to_bcd(PED_TIME);

  // Countdown never reaches 00: the phase advances on the tick seen at 01.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
    else                return {v[7:4] - 4'd1, 4'd9};
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] s);
    case (s)
      ST_NS_G: return ST_NS_Y;
      ST_NS_Y: return ST_AR1;
      ST_AR1:  return ST_EW_G;
      ST_EW_G: return ST_EW_Y;
      ST_EW_Y: return ST_AR2;
      ST_AR2:  return ST_NS_G;
      default: return ST_AR1;
    endcase
  endfunction

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] cnt;   // {giay1, giay0}
    logic       walk;
    logic       pend;
  } ctx_t;

  ctx_t          cur, nxt;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic          req_new;

  assign tick    = en && (presc_q == PRESC_MAX);
  assign req_new = ped_req && !cur.pend;

  // Prescaler: free-running 0..TICK_DIV-1 while enabled.
  always_ff @(posedge CLK) begin
    if (CLR)               presc_q <= '0;
    else if (en) begin
      if (presc_q == PRESC_MAX) presc_q <= '0;
      else                      presc_q <= presc_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (CLR) cur <= '{st: ST_NS_G, cnt: G_BCD, walk: 1'b0, pend: 1'b0};
    else     cur <= nxt;
  end

  // Next-state / countdown / pedestrian bookkeeping.
  always_comb begin
    nxt      = cur;
    // Request latching runs even while frozen by en=0.
    nxt.pend = cur.pend || ped_req;
    if (cur.st > ST_AR2) begin
      // Unreachable codes recover into a plain all-red phase.
      nxt.st   = ST_AR1;
      nxt.cnt  = AR_BCD;
      nxt.walk = 1'b0;
    end else if (tick) begin
      if (cur.cnt == 8'h01) begin
        nxt.st   = succ(cur.st);
        nxt.walk = 1'b0;
        case (succ(cur.st))
          ST_NS_G, ST_EW_G: nxt.cnt = G_BCD;
          ST_NS_Y, ST_EW_Y: nxt.cnt = Y_BCD;
          default: begin
            // All-red entry: a pending request, or one arriving in this
            // very cycle, is served here and consumed.
            if (cur.pend || ped_req) begin
              nxt.cnt  = PED_BCD;
              nxt.walk = 1'b1;
              nxt.pend = 1'b0;
            end else begin
              nxt.cnt  = AR_BCD;
            end
          end
        endcase
      end else begin
        nxt.cnt = bcd_dec(cur.cnt);
      end
    end
  end

  // Output decode.
  always_comb begin
    ns_g = 1'b0; ns_y = 1'b0; ns_r = 1'b0;
    ew_g = 1'b0; ew_y = 1'b0; ew_r = 1'b0;
    case (cur.st)
      ST_NS_G: begin ns_g = 1'b1; ew_r = 1'b1; end
      ST_NS_Y: begin ns_y = 1'b1; ew_r = 1'b1; end
      ST_EW_G: begin ew_g = 1'b1; ns_r = 1'b1; end
      ST_EW_Y: begin ew_y = 1'b1; ns_r = 1'b1; end
      default: begin ns_r = 1'b1; ew_r = 1'b1; end
    endcase
    ped_ack = !CLR && req_new;
    walk    = cur.walk;
    phase   = cur.st;
    giay1   = cur.cnt[7:4];
    giay0   = cur.cnt[3:0];
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;
  logic CLK = 1'b0;
  logic CLR = 1'b1, en = 1'b0, ped_req = 1'b0;

  logic       ped_ack, walk, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
  logic [3:0] giay1, giay0;
  logic [2:0] phase;

  logic       ped_ack12, walk12, ns_g12, ns_y12, ns_r12, ew_g12, ew_y12, ew_r12;
  logic [3:0] giay1_12, giay0_12;
  logic [2:0] phase12;

  int n_chk = 0, n_fail = 0;

  traffic_phase_ctrl #(.TICK_DIV(4), .G_TIME(5), .Y_TIME(2), .AR_TIME(1), .PED_TIME(4)) dut (
    .CLK(CLK), .CLR(CLR), .en(en), .ped_req(ped_req), .ped_ack(ped_ack), .walk(walk),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .giay1(giay1), .giay0(giay0), .phase(phase));

  traffic_phase_ctrl #(.TICK_DIV(4), .G_TIME(12), .Y_TIME(2), .AR_TIME(1), .PED_TIME(4)) dut12 (
    .CLK(CLK), .CLR(CLR), .en(en), .ped_req(ped_req), .ped_ack(ped_ack12), .walk(walk12),
    .ns_g(ns_g12), .ns_y(ns_y12), .ns_r(ns_r12), .ew_g(ew_g12), .ew_y(ew_y12), .ew_r(ew_r12),
    .giay1(giay1_12), .giay0(giay0_12), .phase(phase12));

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Two reset edges; returns 1 ns after the second, CLR released.
  task automatic do_reset();
    CLR = 1'b1; en = 1'b0; ped_req = 1'b0;
    step(); step();
    CLR = 1'b0;
  endtask

  task automatic wait_phase(input logic [2:0] p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (phase == p) begin ok = 1'b1; break; end
      step();
    end
  endtask

  // Starts on the first sample of phase p; returns on the first sample after it.
  task automatic run_len(input logic [2:0] p, output int n, output logic w_all, output logic w_any);
    n = 1; w_all = walk; w_any = walk;
    while (phase == p && n < 200) begin
      step();
      if (phase == p) begin n++; w_all &= walk; w_any |= walk; end
    end
  endtask

  task automatic test_reset();
    // CLR must win over en and ped_req.
    CLR = 1'b1; en = 1'b1; ped_req = 1'b1;
    #1;
    n_chk++; if (ped_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack_gated: got %b want 0", ped_ack); end
    step(); step();
    CLR = 1'b0; en = 1'b0; ped_req = 1'b0;
    n_chk++; if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", phase); end
    n_chk++; if ({giay1, giay0} !== 8'h05) begin n_fail++; $display("FAIL reset_disp: got %h want 05", {giay1, giay0}); end
    n_chk++; if ({ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} !== 6'b100001) begin n_fail++;
      $display("FAIL reset_lamps: got %b want 100001", {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}); end
    n_chk++; if (walk !== 1'b0 || ped_ack !== 1'b0) begin n_fail++; $display("FAIL reset_walk_ack: got %b%b want 00", walk, ped_ack); end
    n_chk++; if ({giay1_12, giay0_12} !== 8'h12) begin n_fail++; $display("FAIL reset_disp12: got %h want 12", {giay1_12, giay0_12}); end
  endtask

  task automatic test_cycle();
    int         exp_len [6] = '{20, 8, 4, 20, 8, 4};
    logic [5:0] exp_lamp[6] = '{6'b100001, 6'b010001, 6'b001001, 6'b001100, 6'b001010, 6'b001001};
    logic [2:0] p;
    int run, idx;
    do_reset();
    en = 1'b1;
    p = phase; run = 1; idx = 0;
    for (int c = 0; c < 64; c++) begin
      step();
      if (phase != p) begin
        if (idx < 6) begin
          n_chk++; if (p !== 3'(idx) || run != exp_len[idx]) begin n_fail++;
            $display("FAIL cycle_len[%0d]: got phase %0d len %0d want phase %0d len %0d", idx, p, run, idx, exp_len[idx]); end
          if (idx < 5) begin
            n_chk++; if ({ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} !== exp_lamp[idx+1]) begin n_fail++;
              $display("FAIL cycle_lamps[%0d]: got %b want %b", idx + 1, {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}, exp_lamp[idx+1]); end
          end
        end
        idx++; p = phase; run = 1;
      end else run++;
    end
    n_chk++; if (idx != 6 || phase !== 3'd0 || {giay1, giay0} !== 8'h05) begin n_fail++;
      $display("FAIL cycle_wrap: got changes %0d phase %0d disp %h want 6 0 05", idx, phase, {giay1, giay0}); end
  endtask

  task automatic test_bcd();
    logic [7:0] want;
    bit bad;
    do_reset();
    en = 1'b1;
    bad = 1'b0;
    for (int k = 11; k >= 1; k--) begin
      repeat (4) step();
      want = {4'(k / 10), 4'(k % 10)};
      if ({giay1_12, giay0_12} !== want || phase12 !== 3'd0) begin
        bad = 1'b1;
        $display("FAIL bcd_step: got %h phase %0d want %h phase 0", {giay1_12, giay0_12}, phase12, want);
      end
    end
    n_chk++; if (bad) n_fail++;
    repeat (4) step();
    n_chk++; if (phase12 !== 3'd1 || {giay1_12, giay0_12} !== 8'h02) begin n_fail++;
      $display("FAIL bcd_to_nsy: got phase %0d disp %h want 1 02", phase12, {giay1_12, giay0_12}); end
  endtask

  task automatic test_ped();
    bit ok; int n; logic wa, wy;
    do_reset();
    en = 1'b1;
    step(); step();
    ped_req = 1'b1; #1;
    n_chk++; if (ped_ack !== 1'b1) begin n_fail++; $display("FAIL ped_ack_first: got %b want 1", ped_ack); end
    step(); ped_req = 1'b0;
    repeat (3) step();
    ped_req = 1'b1; #1;
    n_chk++; if (ped_ack !== 1'b0) begin n_fail++; $display("FAIL ped_ack_second: got %b want 0", ped_ack); end
    step(); ped_req = 1'b0;
    wait_phase(3'd2, ok);
    n_chk++; if (!ok || {giay1, giay0} !== 8'h04) begin n_fail++; $display("FAIL ped_ar1_entry: got ok %0d disp %h want 1 04", ok, {giay1, giay0}); end
    run_len(3'd2, n, wa, wy);
    n_chk++; if (n != 16 || wa !== 1'b1) begin n_fail++; $display("FAIL ped_ar1_len: got len %0d walk %b want 16 1", n, wa); end
    wait_phase(3'd5, ok);
    run_len(3'd5, n, wa, wy);
    n_chk++; if (!ok || n != 4 || wy !== 1'b0) begin n_fail++; $display("FAIL ped_ar2_len: got ok %0d len %0d walk %b want 1 4 0", ok, n, wy); end
  endtask

  task automatic test_entry();
    bit ok; int n; logic wa, wy;
    do_reset();
    en = 1'b1;
    repeat (27) step();
    n_chk++; if (phase !== 3'd1 || {giay1, giay0} !== 8'h01) begin n_fail++;
      $display("FAIL entry_pre: got phase %0d disp %h want 1 01", phase, {giay1, giay0}); end
    ped_req = 1'b1; #1;
    n_chk++; if (ped_ack !== 1'b1) begin n_fail++; $display("FAIL entry_ack: got %b want 1", ped_ack); end
    step(); ped_req = 1'b0;
    n_chk++; if (phase !== 3'd2 || walk !== 1'b1 || {giay1, giay0} !== 8'h04) begin n_fail++;
      $display("FAIL entry_served: got phase %0d walk %b disp %h want 2 1 04", phase, walk, {giay1, giay0}); end
    run_len(3'd2, n, wa, wy);
    n_chk++; if (n != 16 || wa !== 1'b1) begin n_fail++; $display("FAIL entry_ar1_len: got len %0d walk %b want 16 1", n, wa); end
    wait_phase(3'd5, ok);
    run_len(3'd5, n, wa, wy);
    n_chk++; if (!ok || n != 4 || wy !== 1'b0) begin n_fail++; $display("FAIL entry_ar2: got ok %0d len %0d walk %b want 1 4 0", ok, n, wy); end
  endtask

  task automatic test_en();
    do_reset();
    en = 1'b1;
    repeat (9) step();
    n_chk++; if (phase !== 3'd0 || {giay1, giay0} !== 8'h03) begin n_fail++;
      $display("FAIL en_pre: got phase %0d disp %h want 0 03", phase, {giay1, giay0}); end
    en = 1'b0;
    repeat (5) step();
    ped_req = 1'b1; #1;
    n_chk++; if (ped_ack !== 1'b1) begin n_fail++; $display("FAIL en_off_ack: got %b want 1", ped_ack); end
    step(); ped_req = 1'b0;
    repeat (4) step();
    n_chk++; if (phase !== 3'd0 || {giay1, giay0} !== 8'h03 || walk !== 1'b0) begin n_fail++;
      $display("FAIL en_hold: got phase %0d disp %h walk %b want 0 03 0", phase, {giay1, giay0}, walk); end
    en = 1'b1;
    step(); step();
    n_chk++; if ({giay1, giay0} !== 8'h03) begin n_fail++; $display("FAIL en_resume_early: got %h want 03", {giay1, giay0}); end
    step();
    n_chk++; if ({giay1, giay0} !== 8'h02) begin n_fail++; $display("FAIL en_resume_tick: got %h want 02", {giay1, giay0}); end
  endtask

  task automatic test_clr_mid();
    bit ok; int n; logic wa, wy;
    do_reset();
    en = 1'b1;
    wait_phase(3'd4, ok);
    ped_req = 1'b1; #1;
    n_chk++; if (!ok || ped_ack !== 1'b1) begin n_fail++; $display("FAIL clr_pre_ack: got ok %0d ack %b want 1 1", ok, ped_ack); end
    step(); ped_req = 1'b0;
    step();
    CLR = 1'b1; ped_req = 1'b1; #1;
    n_chk++; if (ped_ack !== 1'b0) begin n_fail++; $display("FAIL clr_ack_gated: got %b want 0", ped_ack); end
    step();
    CLR = 1'b0; ped_req = 1'b0;
    n_chk++; if (phase !== 3'd0 || {giay1, giay0} !== 8'h05 || walk !== 1'b0) begin n_fail++;
      $display("FAIL clr_abort: got phase %0d disp %h walk %b want 0 05 0", phase, {giay1, giay0}, walk); end
    wait_phase(3'd2, ok);
    run_len(3'd2, n, wa, wy);
    n_chk++; if (!ok || n != 4 || wy !== 1'b0) begin n_fail++; $display("FAIL clr_pend_cleared: got ok %0d len %0d walk %b want 1 4 0", ok, n, wy); end
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_bcd();
    test_ped();
    test_entry();
    test_en();
    test_clr_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter TICK_DIV, 50000000, CLK cycles per countdown tick (1 s at 50 MHz); legal range >=2.
REQ-002 Parameter G_TIME, 25, green duration in ticks; legal range 1..99.
REQ-003 Parameter Y_TIME, 3, yellow duration in ticks; legal range 1..99.
REQ-004 Parameter AR_TIME, 1, all-red duration in ticks; legal range 1..99.
REQ-005 Parameter PED_TIME, 8, all-red duration when serving a pedestrian; legal range 1..99.
REQ-006 CLK  input  1  single clock; all state SHALL update on posedge CLK only.
REQ-007 CLR  input  1  reset, synchronous, active-high.
REQ-008 en  input  1  run enable; 0 freezes prescaler, countdown and phase.
REQ-009 ped_req  input  1  pedestrian request, level-sampled each cycle.
REQ-010 ped_ack  output  1  one-cycle pulse when a request is latched.
REQ-011 walk  output  1  pedestrian walk lamp.
REQ-012 ns_g, ns_y, ns_r  output  1 each  north-south lamps.
REQ-013 ew_g, ew_y, ew_r  output  1 each  east-west lamps.
REQ-014 giay1, giay0  output  4 each  BCD tens/ones of remaining ticks in current phase.
REQ-015 phase  output  3  current state encoding.

Function
REQ-016 States and encoding SHALL be: NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5; order NS_G->NS_Y->AR1->EW_G->EW_Y->AR2->NS_G.
REQ-017 Lamps SHALL decode from the state: NS_G: ns_g, ew_r; NS_Y: ns_y, ew_r; EW_G: ew_g, ns_r; EW_Y: ew_y, ns_r; AR1/AR2: ns_r, ew_r; exactly one lamp per direction is high at all times.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 while en=1 and wrap to 0; tick is asserted for one cycle when prescaler=TICK_DIV-1 and en=1.
REQ-019 On phase entry, {giay1,giay0} SHALL load the phase duration as two BCD digits.
REQ-020 On a tick, if {giay1,giay0}=01, the block SHALL advance to the next state and load its duration in the same cycle; otherwise it SHALL BCD-decrement.
REQ-021 BCD decrement: ones!=0 -> ones-1; ones=0 -> ones=9, tens-1; the display therefore shows D down to 1, each value held one tick period.
REQ-022 The display SHALL never show 00 or a non-BCD digit.
REQ-023 A pending flag pend SHALL be set when ped_req=1 and pend=0; ped_ack SHALL pulse high in that same cycle.
REQ-024 ped_req while pend=1 SHALL be ignored, with no ped_ack.
REQ-025 On entry to AR1 or AR2 with pend=1, the phase SHALL load PED_TIME instead of AR_TIME, assert walk for the whole phase, and clear pend.
REQ-026 ped_req=1 in the cycle of entry to AR1/AR2 with pend=0 SHALL be served by that phase: ped_ack pulses, PED_TIME is loaded, walk=1, and pend stays 0.
REQ-027 walk SHALL be 0 in all other states.
REQ-028 With en=0, prescaler, digits, state and walk SHALL hold; pend latching and ped_ack SHALL still operate.
REQ-029 Illegal state codes 6/7 SHALL go to AR1 with AR_TIME loaded on the next cycle.

Reset
REQ-030 CLR=1 at a clock edge SHALL force: state NS_G, {giay1,giay0}=G_TIME, prescaler=0, pend=0, ped_ack=0, walk=0.
REQ-031 CLR SHALL take priority over en, tick and ped_req.
REQ-032 CLR asserted mid-phase SHALL abort the current phase without completing it.

Verification (TICK_DIV=4, G_TIME=5, Y_TIME=2, AR_TIME=1, PED_TIME=4 unless noted)
REQ-033 CLR=1 for 2 cycles, then 0 -> phase=0, giay1=0, giay0=5, ns_g=1, ew_r=1, walk=0, ped_ack=0.
REQ-034 en=1, no ped_req, 64 cycles -> phase sequence 0,1,2,3,4,5 lasting 20,8,4,20,8,4 cycles, then back to phase=0 with giay0=5.
REQ-035 G_TIME=12 -> display 1/2, 1/1, 1/0, 0/9, ..., 0/1, then NS_Y is entered.
REQ-036 ped_req pulse in NS_G -> ped_ack for 1 cycle; second ped_req ignored; AR1 lasts 16 cycles with walk=1; following AR2 lasts 4 cycles with walk=0.
REQ-037 en=0 for 10 cycles mid NS_G at display 3 -> display, prescaler and phase unchanged; resumes exactly on en=1.
REQ-038 CLR=1 during EW_Y with pend=1 -> next cycle phase=0, giay0=5, pend=0; following AR1 uses AR_TIME, walk=0.
